// File: rtl/lcd_stream_monitor.sv
// lcd_stream_monitor: receive side of the parallel-RGB panel stream.
// Rebuilds pixel coordinates from HSYNC/VSYNC, verifies line and frame
// timing, and exposes a per-frame checksum and a single-pixel probe.
module lcd_stream_monitor #(
    parameter int unsigned H_ACTIVE    = 480,
    parameter int unsigned V_ACTIVE    = 272,
    parameter int unsigned H_TOTAL     = 526,
    parameter int unsigned V_TOTAL     = 286,
    parameter int unsigned H_BACK      = 43,
    parameter int unsigned V_BACK      = 12,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic        clk12,
    input  logic        reset,
    input  logic [23:0] bgr_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        disp_in,
    input  logic        err_clear,
    input  logic [8:0]  probe_x,
    input  logic [8:0]  probe_y,
    output logic [8:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [23:0] pix_bgr,
    output logic        pix_valid,
    output logic [23:0] probe_bgr,
    output logic        probe_done,
    output logic [23:0] frame_sum,
    output logic        frame_done,
    output logic        locked,
    output logic        line_err,
    output logic        frame_err
);

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_MEASURE,
        ST_LOCKED
    } state_t;

    // input stage
    logic [23:0] r_bgr;
    logic        r_hs, r_hs_d, r_vs, r_vs_d, r_disp;
    logic        w_hrise, w_vrise;

    // timing counters
    logic [9:0]  r_h_cnt, w_h_cnt;
    logic [9:0]  r_line_cnt, w_line_cnt;
    logic [10:0] w_period;
    logic        w_per_bad, w_lines_ok;

    // active window
    logic [9:0]  w_x, w_y;
    logic        w_in_win;

    // FSM
    state_t      r_state, w_state_nxt;
    logic [7:0]  r_good_cnt, w_good_nxt;
    logic        r_frame_bad, w_bad_nxt;
    logic        r_chk_en, w_chk_nxt;
    logic        w_set_le, w_set_fe, w_fdone;

    // output registers
    logic [8:0]  r_pix_x, r_pix_y;
    logic [23:0] r_pix_bgr, r_probe_bgr, r_frame_sum, r_acc;
    logic        r_pix_valid, r_probe_done, r_frame_done;
    logic        r_locked, r_line_err, r_frame_err;
    logic        w_probe_hit;

    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_bgr    = r_pix_bgr;
    assign pix_valid  = r_pix_valid;
    assign probe_bgr  = r_probe_bgr;
    assign probe_done = r_probe_done;
    assign frame_sum  = r_frame_sum;
    assign frame_done = r_frame_done;
    assign locked     = r_locked;
    assign line_err   = r_line_err;
    assign frame_err  = r_frame_err;

    // Register the pins once and keep a delayed copy of the syncs for edge detect
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_bgr  <= '0;
            r_hs   <= 1'b0;
            r_hs_d <= 1'b0;
            r_vs   <= 1'b0;
            r_vs_d <= 1'b0;
            r_disp <= 1'b0;
        end else begin
            r_bgr  <= bgr_in;
            r_hs   <= hsync_in;
            r_hs_d <= r_hs;
            r_vs   <= vsync_in;
            r_vs_d <= r_vs;
            r_disp <= disp_in;
        end
    end

    assign w_hrise = r_hs & ~r_hs_d;
    assign w_vrise = r_vs & ~r_vs_d;

    // Current-cycle column and line counts, so the sync-rise cycle itself reads 0
    always_comb begin
        w_h_cnt = r_h_cnt;
        if (w_hrise)
            w_h_cnt = '0;
        else if (r_h_cnt != '1)
            w_h_cnt = r_h_cnt + 10'd1;

        w_line_cnt = r_line_cnt;
        if (w_vrise)
            w_line_cnt = w_hrise ? 10'd1 : 10'd0;
        else if (w_hrise && (r_line_cnt != '1))
            w_line_cnt = r_line_cnt + 10'd1;
    end

    // Hold the counts for the next cycle
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_h_cnt    <= '0;
            r_line_cnt <= '0;
        end else begin
            r_h_cnt    <= w_h_cnt;
            r_line_cnt <= w_line_cnt;
        end
    end

    assign w_period   = {1'b0, r_h_cnt} + 11'd1;
    assign w_per_bad  = w_hrise && r_chk_en && (w_period != 11'(H_TOTAL));
    assign w_lines_ok = (r_line_cnt == 10'(V_TOTAL));

    assign w_x      = w_h_cnt - 10'(H_BACK);
    assign w_y      = w_line_cnt - 10'(V_BACK);
    assign w_in_win = (w_h_cnt >= 10'(H_BACK)) && (w_x < 10'(H_ACTIVE)) &&
                      (w_line_cnt >= 10'(V_BACK)) && (w_y < 10'(V_ACTIVE));

    // Lock FSM state register
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_state     <= ST_SEARCH;
            r_good_cnt  <= '0;
            r_frame_bad <= 1'b0;
            r_chk_en    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_good_cnt  <= w_good_nxt;
            r_frame_bad <= w_bad_nxt;
            r_chk_en    <= w_chk_nxt;
        end
    end

    // Lock FSM next-state and event decode
    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_bad_nxt   = r_frame_bad;
        w_chk_nxt   = r_chk_en;
        w_set_le    = 1'b0;
        w_set_fe    = 1'b0;
        w_fdone     = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_vrise) begin
                    w_state_nxt = ST_MEASURE;
                    w_good_nxt  = '0;
                    w_bad_nxt   = 1'b0;
                    w_chk_nxt   = 1'b0;
                end
            end
            ST_MEASURE: begin
                if (w_hrise)
                    w_chk_nxt = 1'b1;
                if (w_per_bad)
                    w_bad_nxt = 1'b1;
                if (w_vrise) begin
                    w_bad_nxt = 1'b0;
                    if (!r_frame_bad && !w_per_bad && w_lines_ok) begin
                        w_good_nxt = r_good_cnt + 8'd1;
                        if (w_good_nxt >= 8'(LOCK_FRAMES))
                            w_state_nxt = ST_LOCKED;
                    end else begin
                        w_good_nxt = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (w_hrise)
                    w_chk_nxt = 1'b1;
                // A bad line also marks the current frame bad so it cannot count towards relock
                if (w_per_bad) begin
                    w_set_le    = 1'b1;
                    w_state_nxt = ST_MEASURE;
                    w_good_nxt  = '0;
                    w_chk_nxt   = 1'b0;
                    w_bad_nxt   = ~w_vrise;
                end
                if (w_vrise) begin
                    if (!w_lines_ok) begin
                        w_set_fe    = 1'b1;
                        w_state_nxt = ST_MEASURE;
                        w_good_nxt  = '0;
                        w_chk_nxt   = 1'b0;
                    end else if (!w_per_bad) begin
                        w_fdone = 1'b1;
                    end
                end else if (w_line_cnt == '1) begin
                    w_set_fe    = 1'b1;
                    w_state_nxt = ST_MEASURE;
                    w_good_nxt  = '0;
                    w_chk_nxt   = 1'b0;
                end
            end
            default: w_state_nxt = ST_SEARCH;
        endcase
    end

    // Status flags, checksum capture and lock indication
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_locked     <= 1'b0;
            r_line_err   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_sum  <= '0;
            r_acc        <= '0;
        end else begin
            r_locked     <= (w_state_nxt == ST_LOCKED);
            r_line_err   <= w_set_le | (r_line_err & ~err_clear);
            r_frame_err  <= w_set_fe | (r_frame_err & ~err_clear);
            r_frame_done <= w_fdone;
            if (w_fdone)
                r_frame_sum <= r_acc;
            if (w_vrise)
                r_acc <= '0;
            else if (r_pix_valid)
                r_acc <= r_acc + r_pix_bgr;
        end
    end

    // Registered pixel outputs
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_pix_bgr   <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r_pix_x     <= w_x[8:0];
            r_pix_y     <= w_y[8:0];
            r_pix_bgr   <= r_bgr;
            r_pix_valid <= r_locked && r_disp && w_in_win;
        end
    end

    assign w_probe_hit = r_pix_valid && (r_pix_x == probe_x) && (r_pix_y == probe_y);

    // Probe capture on coordinate match
    always_ff @(posedge clk12) begin
        if (reset) begin
            r_probe_bgr  <= '0;
            r_probe_done <= 1'b0;
        end else begin
            r_probe_done <= w_probe_hit;
            if (w_probe_hit)
                r_probe_bgr <= r_pix_bgr;
        end
    end

endmodule

// File: tb/tb_lcd_stream_monitor.sv
// Testbench for lcd_stream_monitor: drives a reduced-size panel timing
// with randomized pixel data and scoreboards pixels, probe hits and
// frame checksums against a frame-level reference model.
module tb_lcd_stream_monitor;

    localparam int H_ACT = 32;
    localparam int V_ACT = 12;
    localparam int H_TOT = 46;
    localparam int V_TOT = 18;
    localparam int H_BK  = 7;
    localparam int V_BK  = 3;
    localparam int LOCKF = 2;
    localparam int HSW   = 4;
    localparam int VSW   = 2;

    logic        clk12 = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] bgr_in = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, disp_in = 1'b0, err_clear = 1'b0;
    logic [8:0]  probe_x = '0, probe_y = '0;
    logic [8:0]  pix_x, pix_y;
    logic [23:0] pix_bgr, probe_bgr, frame_sum;
    logic        pix_valid, probe_done, frame_done, locked, line_err, frame_err;

    lcd_stream_monitor #(
        .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .H_TOTAL(H_TOT), .V_TOTAL(V_TOT),
        .H_BACK(H_BK), .V_BACK(V_BK), .LOCK_FRAMES(LOCKF)
    ) dut (
        .clk12(clk12), .reset(reset), .bgr_in(bgr_in), .hsync_in(hsync_in),
        .vsync_in(vsync_in), .disp_in(disp_in), .err_clear(err_clear),
        .probe_x(probe_x), .probe_y(probe_y), .pix_x(pix_x), .pix_y(pix_y),
        .pix_bgr(pix_bgr), .pix_valid(pix_valid), .probe_bgr(probe_bgr),
        .probe_done(probe_done), .frame_sum(frame_sum), .frame_done(frame_done),
        .locked(locked), .line_err(line_err), .frame_err(frame_err)
    );

    always #5 clk12 = ~clk12;

    typedef struct {
        int          x;
        int          y;
        logic [23:0] bgr;
    } pix_t;

    pix_t        pix_q[$];
    logic [23:0] sum_q[$];
    logic [23:0] probe_q[$];
    pix_t        mon_e;
    logic [23:0] mon_v;

    int n_tests = 0;
    int n_fail  = 0;

    // frame-level reference model
    bit          m_search = 1'b1;
    bit          m_lock   = 1'b0;
    bit          m_le     = 1'b0;
    bit          m_fe     = 1'b0;
    int          m_good   = 0;
    int          p_lines  = 0;
    bit          p_stretch = 1'b0;
    logic [23:0] p_sum    = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Evaluate the frame that ends at this VSYNC rise
    task automatic frame_boundary();
        bit ok;
        if (m_search) begin
            m_search = 1'b0;
            m_good   = 0;
        end else begin
            ok = (p_lines == V_TOT) && !p_stretch;
            if (m_lock) begin
                if (ok) sum_q.push_back(p_sum);
                else begin
                    m_fe   = 1'b1;
                    m_lock = 1'b0;
                    m_good = 0;
                end
            end else if (ok) begin
                m_good++;
                if (m_good >= LOCKF) m_lock = 1'b1;
            end else begin
                m_good = 0;
            end
        end
    endtask

    task automatic drive_frame(input int nlines, input int stretch_v, input bit disp_on,
                               input int mode, input int rst_v, input int clr_v,
                               input int prx, input int pry);
        logic [23:0] px, fsum;
        int hlen, x, y;
        bit inwin;
        frame_boundary();
        probe_x = 9'(prx);
        probe_y = 9'(pry);
        fsum = '0;
        for (int v = 0; v < nlines; v++) begin
            hlen = (v == stretch_v) ? H_TOT + 1 : H_TOT;
            for (int h = 0; h < hlen; h++) begin
                @(posedge clk12);
                #1;
                reset     = (v == rst_v) && (h == 20);
                err_clear = (v == clr_v) && (h == 10);
                if (reset) begin
                    m_search = 1'b1; m_lock = 1'b0; m_good = 0; m_le = 1'b0; m_fe = 1'b0;
                end
                if (err_clear) begin
                    m_le = 1'b0; m_fe = 1'b0;
                end
                if (v == rst_v && h == 21)
                    check("reset_outputs",
                          {pix_x, pix_y, pix_bgr, pix_valid, probe_bgr, probe_done,
                           frame_sum, frame_done, locked, line_err, frame_err}, '0);
                if (stretch_v >= 0 && v == stretch_v + 1 && h == 0 && m_lock) begin
                    m_lock = 1'b0; m_le = 1'b1; m_good = 0;
                end
                if (h == 8 && (v == 0 || v == 2 || v == 4)) begin
                    check("locked", locked, m_lock);
                    check("line_err", line_err, m_le);
                    check("frame_err", frame_err, m_fe);
                end
                hsync_in = (h < HSW);
                vsync_in = (v < VSW);
                disp_in  = disp_on;
                // rows count from the VSYNC line, which is itself the first HSYNC rise
                x = h - H_BK;
                y = v + 1 - V_BK;
                inwin = (x >= 0) && (x < H_ACT) && (y >= 0) && (y < V_ACT);
                px = 24'($urandom());
                if (mode == 0) px = 24'h000001;
                else if (mode == 1 && inwin && (x == 0 || y == 0 || x == H_ACT - 1 || y == V_ACT - 1))
                    px = 24'h00FE00;
                bgr_in = px;
                if (inwin && disp_on && m_lock) begin
                    pix_q.push_back('{x, y, px});
                    fsum = fsum + px;
                    if (x == prx && y == pry) probe_q.push_back(px);
                end
            end
        end
        p_lines   = nlines;
        p_stretch = (stretch_v >= 0);
        p_sum     = fsum;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk12);
            #1;
            hsync_in = 1'b0; vsync_in = 1'b0; disp_in = 1'b0; err_clear = 1'b0; bgr_in = '0;
        end
    endtask

    // Pixel, probe and checksum monitors
    always @(negedge clk12) begin
        if (pix_valid) begin
            if (pix_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL pix_unexpected: got x=%0d y=%0d bgr=%06h, expected no pixel", pix_x, pix_y, pix_bgr);
            end else begin
                mon_e = pix_q.pop_front();
                check("pixel", {pix_x, pix_y, pix_bgr}, {9'(mon_e.x), 9'(mon_e.y), mon_e.bgr});
            end
        end
        if (probe_done) begin
            if (probe_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL probe_unexpected: got probe_bgr=%06h, expected no probe_done", probe_bgr);
            end else begin
                mon_v = probe_q.pop_front();
                check("probe_bgr", probe_bgr, mon_v);
            end
        end
        if (frame_done) begin
            if (sum_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL frame_done_unexpected: got frame_sum=%06h, expected no frame_done", frame_sum);
            end else begin
                mon_v = sum_q.pop_front();
                check("frame_sum", frame_sum, mon_v);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(posedge clk12);
        #1;
        check("reset_state",
              {pix_x, pix_y, pix_bgr, pix_valid, probe_bgr, probe_done,
               frame_sum, frame_done, locked, line_err, frame_err}, '0);
        reset = 1'b0;
        idle(10);
        // constant 1 pixels: lock after third VSYNC rise, full-frame sum at fourth
        for (int f = 0; f < 4; f++) drive_frame(V_TOT, -1, 1, 0, -1, -1, 0, 0);
        drive_frame(V_TOT, -1, 1, 1, -1, -1, 0, 0);
        drive_frame(V_TOT, -1, 1, 1, -1, -1, H_ACT - 1, V_ACT - 1);
        drive_frame(V_TOT, -1, 1, 2, -1, -1, H_ACT, 0);
        // stretched line while locked, then relock
        drive_frame(V_TOT, 0, 1, 2, -1, -1, $urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1));
        for (int f = 0; f < 3; f++)
            drive_frame(V_TOT, -1, 1, 2, -1, -1, $urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1));
        drive_frame(V_TOT, -1, 1, 2, -1, 3, $urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1));
        // dropped line while locked
        drive_frame(V_TOT - 1, -1, 1, 2, -1, -1, $urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1));
        drive_frame(V_TOT, -1, 1, 2, -1, 3, 0, 0);
        drive_frame(V_TOT, -1, 1, 2, -1, -1, 0, 0);
        // display disabled for a locked frame
        drive_frame(V_TOT, -1, 0, 2, -1, -1, 0, 0);
        // reset mid-frame, then relock
        drive_frame(V_TOT, -1, 1, 2, 1, -1, 0, 0);
        for (int f = 0; f < 4; f++)
            drive_frame(V_TOT, -1, 1, 2, -1, -1, $urandom_range(0, H_ACT - 1), $urandom_range(0, V_ACT - 1));
        idle(20);
        check("pix_queue_empty", pix_q.size(), 0);
        check("probe_queue_empty", probe_q.size(), 0);
        check("sum_queue_empty", sum_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/lcd_stream_monitor.md
Name: lcd_stream_monitor

Overview:
- Receiving end of the 480x272 LCD parallel-RGB stream (BGR, HSYNC, VSYNC, DISP) that our panel driver produces.
- Reconstructs pixel coordinates from the sync pulses and checks line and frame timing against nominal values.
- Exports a per-frame checksum and a programmable single-pixel probe.
- Used as an on-chip self-test and scoreboard tap next to the panel driver, so board rendering and cursor colours can be checked without a camera.

Parameters:
- H_ACTIVE, 480, active pixels per line.
- V_ACTIVE, 272, active lines per frame.
- H_TOTAL, 526, expected clocks between HSYNC rising edges.
- V_TOTAL, 286, expected HSYNC rising edges between VSYNC rising edges.
- H_BACK, 43, clocks from the HSYNC-rise cycle to pixel x=0.
- V_BACK, 12, HSYNC rises after a VSYNC rise before row y=0.
- LOCK_FRAMES, 2, consecutive good frames required to lock.

Ports:
- clk12 in 1: pixel clock.
- reset in 1: synchronous, active-high.
- bgr_in in 24: pixel data {B,G,R}.
- hsync_in in 1: active-high line sync.
- vsync_in in 1: active-high frame sync.
- disp_in in 1: display enable; pixels are ignored when low.
- err_clear in 1: clears the sticky error flags.
- probe_x in 9: probe column.
- probe_y in 9: probe row.
- pix_x out 9: current pixel column.
- pix_y out 9: current pixel row.
- pix_bgr out 24: current pixel data.
- pix_valid out 1: pix_x, pix_y, pix_bgr are valid.
- probe_bgr out 24: last captured probe pixel.
- probe_done out 1: one-cycle pulse on probe capture.
- frame_sum out 24: last completed frame checksum.
- frame_done out 1: one-cycle pulse when frame_sum updates.
- locked out 1: stream timing verified.
- line_err out 1: sticky, line-length violation.
- frame_err out 1: sticky, line-count violation.

Behaviour:
- Reset:
  - All outputs are 0.
  - FSM goes to SEARCH.
  - Input registers and all counters clear.
- Input stage:
  - bgr_in, hsync_in, vsync_in and disp_in are registered once.
  - Rise detect on registered syncs: rise = reg & ~reg_d.
  - All later logic uses the registered copies, so relative alignment is preserved.
- h_cnt (10 bit):
  - 0 on the HSYNC-rise cycle; otherwise +1, saturating at 1023.
  - Line period = h_cnt+1 sampled at the next HSYNC rise.
  - No period is checked for the first HSYNC rise after entering MEASURE.
- line_cnt (10 bit):
  - 0 on VSYNC rise; +1 on each HSYNC rise, saturating.
  - Simultaneous VSYNC and HSYNC rise loads 1.
- Active window:
  - x = h_cnt - H_BACK, valid in 0..H_ACTIVE-1.
  - y = line_cnt - V_BACK, valid in 0..V_ACTIVE-1.
- pix_valid:
  - Asserted when locked, registered disp is high, and both x and y are in window.
  - pix_* are registered; latency is 2 clk12 from the input pins.
- FSM states:
  - SEARCH: on the first VSYNC rise, go to MEASURE with good_cnt=0 and the frame-bad flag clear.
  - MEASURE:
    - Any checked line period != H_TOTAL sets frame-bad.
    - On VSYNC rise, the frame is good if frame-bad is clear and line_cnt (pre-clear) == V_TOTAL.
    - Good frame: good_cnt+1. Bad frame: good_cnt=0.
    - When good_cnt reaches LOCK_FRAMES, go to LOCKED; locked=1 on the cycle after that VSYNC rise.
    - frame-bad clears at every VSYNC rise.
  - LOCKED:
    - Line period != H_TOTAL: set line_err, go to MEASURE, good_cnt=0.
    - VSYNC rise with line_cnt != V_TOTAL: set frame_err, go to MEASURE.
    - line_cnt reaching 1023 with no VSYNC rise: set frame_err, go to MEASURE.
    - locked deasserts on the cycle after the violating edge.
- Error flags:
  - line_err and frame_err are set only in LOCKED.
  - Both clear on err_clear.
  - err_clear and a set on the same cycle: set wins.
- Checksum:
  - acc += bgr for every pix_valid pixel, 24-bit wrap.
  - On VSYNC rise while LOCKED with a good frame: frame_sum<=acc and frame_done pulses.
  - acc clears on every VSYNC rise.
  - Frames that end with a lock loss produce no frame_done.
- Probe:
  - When pix_valid and pix_x==probe_x and pix_y==probe_y: probe_bgr<=pix_bgr, and probe_done pulses the following cycle.
  - probe_x and probe_y may change at any time and take effect immediately.
  - An out-of-range probe never fires.
- Reset mid-frame: everything returns to SEARCH and relocks per the FSM.

Test Plan:
- Panel-driver timing model, constant bgr 0x000001, disp=1, LOCK_FRAMES=2 -> locked rises one cycle after the 3rd VSYNC rise; the 4th VSYNC rise gives frame_done with frame_sum=0x01FE00 (480*272).
- Probe (0,0) with first active pixel green border 0x00FE00 -> probe_bgr=0x00FE00 with one probe_done per frame. Probe (479,271) -> fires on the last active pixel. Probe (480,0) -> never fires.
- While locked, stretch one line to 527 clocks -> line_err=1 and locked=0 next cycle. Relock after 2 good frames. line_err stays 1 until err_clear.
- While locked, drop one line (285 HSYNC rises per frame) -> frame_err=1, no frame_done that frame, locked=0.
- disp_in=0 for a whole locked frame -> no pix_valid, and frame_done with frame_sum=0.
- Assert reset mid-frame for 1 cycle -> all outputs 0 next cycle; locked reasserts only after the 3rd subsequent VSYNC rise.
